// File: rtl/sar_search.sv
// Successive-approximation search controller: probes a comparator with a candidate guess and binary-searches the target.
// Optional build macro SAR_ONEHOT_CHECK_EN adds an err output that aborts on non-one-hot comparator flags.
module sar_search #(
    parameter int WIDTH = 8,
    localparam int SW = $clog2(WIDTH + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] guess,
    input  logic             cmp_less,
    input  logic             cmp_equal,
    input  logic             cmp_greater,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [WIDTH-1:0] result,
    output logic [SW-1:0]    steps
`ifdef SAR_ONEHOT_CHECK_EN
    ,
    output logic             err
`endif
);

    // Two extra bits keep lo=2**WIDTH and hi=-1 representable so lo>hi detects exhaustion.
    localparam int BW = WIDTH + 2;
    localparam logic signed [BW-1:0] HI_INIT    = BW'((2 ** WIDTH) - 1);
    localparam logic signed [BW-1:0] ONE        = BW'(1);
    localparam logic [WIDTH-1:0]     GUESS_INIT = WIDTH'((2 ** (WIDTH - 1)) - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_DONE
    } state_t;

    state_t               state, state_n;
    logic signed [BW-1:0] lo, hi, lo_n, hi_n, guess_ext;
    logic [WIDTH-1:0]     guess_n, result_n;
    logic                 found_n, abort;
    logic [SW-1:0]        steps_n;
`ifdef SAR_ONEHOT_CHECK_EN
    logic                 err_n;
`endif

    assign busy      = (state == ST_SEARCH);
    assign done      = (state == ST_DONE);
    assign guess_ext = signed'({2'b00, guess});

`ifdef SAR_ONEHOT_CHECK_EN
    assign abort = !$onehot({cmp_less, cmp_equal, cmp_greater});
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_n  = state;
        guess_n  = guess;
        lo_n     = lo;
        hi_n     = hi;
        found_n  = found;
        result_n = result;
        steps_n  = steps;
`ifdef SAR_ONEHOT_CHECK_EN
        err_n    = err;
`endif
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n  = ST_SEARCH;
                    lo_n     = '0;
                    hi_n     = HI_INIT;
                    guess_n  = GUESS_INIT;
                    steps_n  = '0;
                    found_n  = 1'b0;
                    result_n = '0;
`ifdef SAR_ONEHOT_CHECK_EN
                    err_n    = 1'b0;
`endif
                end
            end
            ST_SEARCH: begin
                steps_n = steps + SW'(1);
                if (abort) begin
                    result_n = '0;
                    found_n  = 1'b0;
                    state_n  = ST_DONE;
`ifdef SAR_ONEHOT_CHECK_EN
                    err_n    = 1'b1;
`endif
                end else if (cmp_equal) begin
                    result_n = guess;
                    found_n  = 1'b1;
                    state_n  = ST_DONE;
                end else begin
                    // Reaching here with no flag set narrows downward, same as greater.
                    if (cmp_less)
                        lo_n = guess_ext + ONE;
                    else if (cmp_greater || !cmp_equal)
                        hi_n = guess_ext - ONE;
                    if (lo_n > hi_n) begin
                        result_n = '0;
                        found_n  = 1'b0;
                        state_n  = ST_DONE;
                    end else begin
                        guess_n = WIDTH'((lo_n + hi_n) >>> 1);
                    end
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            guess  <= '0;
            lo     <= '0;
            hi     <= HI_INIT;
            found  <= 1'b0;
            result <= '0;
            steps  <= '0;
`ifdef SAR_ONEHOT_CHECK_EN
            err    <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            guess  <= guess_n;
            lo     <= lo_n;
            hi     <= hi_n;
            found  <= found_n;
            result <= result_n;
            steps  <= steps_n;
`ifdef SAR_ONEHOT_CHECK_EN
            err    <= err_n;
`endif
        end
    end

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search (WIDTH=8) with a behavioural comparator driven from a target value.
module tb_sar_search;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [7:0] guess, result;
    logic       cmp_less, cmp_equal, cmp_greater;
    logic       busy, done, found;
    logic [3:0] steps;
`ifdef SAR_ONEHOT_CHECK_EN
    logic       err;
`endif

    logic [7:0] target;
    logic       force_less, force_none, inject_bad;
    bit         ignore_starts;
    int         checks = 0;
    int         fails  = 0;
    int         probes[16];
    int         nprobe, done_cycle;
    bit         done_seen;

    always #5 clk = ~clk;

    always_comb begin
        cmp_less    = (guess < target);
        cmp_equal   = (guess == target);
        cmp_greater = (guess > target);
        if (force_less) {cmp_less, cmp_equal, cmp_greater} = 3'b100;
        if (force_none) {cmp_less, cmp_equal, cmp_greater} = 3'b000;
        if (inject_bad && guess == 8'd63) {cmp_less, cmp_equal, cmp_greater} = 3'b101;
    end

    sar_search #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .guess(guess),
        .cmp_less(cmp_less), .cmp_equal(cmp_equal), .cmp_greater(cmp_greater),
        .busy(busy), .done(done), .found(found), .result(result), .steps(steps)
`ifdef SAR_ONEHOT_CHECK_EN
        , .err(err)
`endif
    );

    // Pulses start, then records each probed guess until done or the cycle budget runs out.
    task automatic do_search(input logic [7:0] tgt);
        target = tgt;
        nprobe = 0;
        done_seen = 0;
        done_cycle = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 1; c <= 20 && !done_seen; c++) begin
            @(negedge clk);
            if (busy) begin
                if (nprobe < 16) probes[nprobe] = guess;
                nprobe++;
            end
            if (done) begin
                done_seen = 1;
                done_cycle = c;
            end
            start = ignore_starts && busy && (c == 2 || c == 3);
        end
        start = 1'b0;
        checks++;
        if (!done_seen) begin
            fails++;
            $display("FAIL search_timeout target=%0d got no done want done within 20 cycles", tgt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done} !== 2'b00) begin
            fails++; $display("FAIL reset_busy_done got %b want 00", {busy, done});
        end
        checks++;
        if (guess !== 8'd0) begin
            fails++; $display("FAIL reset_guess got %0d want 0", guess);
        end
        checks++;
        if ({found, result, steps} !== 13'd0) begin
            fails++; $display("FAIL reset_outputs got found=%b result=%0d steps=%0d want 0", found, result, steps);
        end
`ifdef SAR_ONEHOT_CHECK_EN
        checks++;
        if (err !== 1'b0) begin
            fails++; $display("FAIL reset_err got %b want 0", err);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_target_zero(input string tag);
        int exp_g[8] = '{127, 63, 31, 15, 7, 3, 1, 0};
        do_search(8'h00);
        checks++;
        if (nprobe !== 8) begin
            fails++; $display("FAIL %s_nprobe got %0d want 8", tag, nprobe);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (probes[i] !== exp_g[i]) begin
                fails++; $display("FAIL %s_probe%0d got %0d want %0d", tag, i, probes[i], exp_g[i]);
            end
        end
        checks++;
        if (done_cycle !== 9) begin
            fails++; $display("FAIL %s_done_cycle got %0d want 9", tag, done_cycle);
        end
        checks++;
        if ({found, result, steps, busy} !== {1'b1, 8'd0, 4'd8, 1'b0}) begin
            fails++; $display("FAIL %s_outputs got found=%b result=%0d steps=%0d busy=%b want 1/0/8/0", tag, found, result, steps, busy);
        end
        @(negedge clk);
        checks++;
        if ({done, found, steps} !== {1'b0, 1'b1, 4'd8}) begin
            fails++; $display("FAIL %s_hold got done=%b found=%b steps=%0d want 0/1/8", tag, done, found, steps);
        end
    endtask

    task automatic test_target_max();
        int exp_g[9] = '{127, 191, 223, 239, 247, 251, 253, 254, 255};
        do_search(8'hFF);
        checks++;
        if (nprobe !== 9) begin
            fails++; $display("FAIL max_nprobe got %0d want 9", nprobe);
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (probes[i] !== exp_g[i]) begin
                fails++; $display("FAIL max_probe%0d got %0d want %0d", i, probes[i], exp_g[i]);
            end
        end
        checks++;
        if ({found, result, steps} !== {1'b1, 8'd255, 4'd9}) begin
            fails++; $display("FAIL max_outputs got found=%b result=%0d steps=%0d want 1/255/9", found, result, steps);
        end
    endtask

    task automatic test_first_probe_hit();
        do_search(8'h7F);
        checks++;
        if (nprobe !== 1 || done_cycle !== 2) begin
            fails++; $display("FAIL mid_latency got probes=%0d done_cycle=%0d want 1/2", nprobe, done_cycle);
        end
        checks++;
        if ({found, result, steps} !== {1'b1, 8'd127, 4'd1}) begin
            fails++; $display("FAIL mid_outputs got found=%b result=%0d steps=%0d want 1/127/1", found, result, steps);
        end
    endtask

    task automatic test_beyond_range();
        int exp_g[9] = '{127, 191, 223, 239, 247, 251, 253, 254, 255};
        force_less = 1'b1;
        do_search(8'h00);
        force_less = 1'b0;
        checks++;
        if (nprobe !== 9) begin
            fails++; $display("FAIL beyond_nprobe got %0d want 9", nprobe);
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (probes[i] !== exp_g[i]) begin
                fails++; $display("FAIL beyond_probe%0d got %0d want %0d", i, probes[i], exp_g[i]);
            end
        end
        checks++;
        if ({found, result, steps} !== {1'b0, 8'd0, 4'd9}) begin
            fails++; $display("FAIL beyond_outputs got found=%b result=%0d steps=%0d want 0/0/9", found, result, steps);
        end
    endtask

`ifndef SAR_ONEHOT_CHECK_EN
    task automatic test_no_flags();
        force_none = 1'b1;
        do_search(8'h00);
        force_none = 1'b0;
        checks++;
        if (nprobe !== 8 || probes[7] !== 0) begin
            fails++; $display("FAIL none_probes got n=%0d last=%0d want 8/0", nprobe, probes[7]);
        end
        checks++;
        if ({found, result, steps} !== {1'b0, 8'd0, 4'd8}) begin
            fails++; $display("FAIL none_outputs got found=%b result=%0d steps=%0d want 0/0/8", found, result, steps);
        end
    endtask
`endif

    task automatic test_reset_mid_search();
        bit saw_done = 0;
        target = 8'h00;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (guess !== 8'd15 || busy !== 1'b1) begin
            fails++; $display("FAIL rstmid_probe4 got guess=%0d busy=%b want 15/1", guess, busy);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, found, guess, result, steps} !== 23'd0) begin
            fails++; $display("FAIL rstmid_cleared got busy=%b done=%b found=%b guess=%0d result=%0d steps=%0d want all 0",
                              busy, done, found, guess, result, steps);
        end
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1;
        end
        checks++;
        if (saw_done) begin
            fails++; $display("FAIL rstmid_idle got activity after reset want idle");
        end
    endtask

`ifdef SAR_ONEHOT_CHECK_EN
    task automatic test_onehot_abort();
        inject_bad = 1'b1;
        do_search(8'h00);
        inject_bad = 1'b0;
        checks++;
        if (nprobe !== 2 || done_cycle !== 3) begin
            fails++; $display("FAIL abort_latency got probes=%0d done_cycle=%0d want 2/3", nprobe, done_cycle);
        end
        checks++;
        if ({err, found, result, steps} !== {1'b1, 1'b0, 8'd0, 4'd2}) begin
            fails++; $display("FAIL abort_outputs got err=%b found=%b result=%0d steps=%0d want 1/0/0/2", err, found, result, steps);
        end
        do_search(8'h7F);
        checks++;
        if ({err, found} !== 2'b01) begin
            fails++; $display("FAIL abort_err_clear got err=%b found=%b want 0/1", err, found);
        end
    endtask
`endif

    initial begin
        rst = 1'b0; start = 1'b0; target = 8'h00;
        force_less = 1'b0; force_none = 1'b0; inject_bad = 1'b0; ignore_starts = 0;
        test_reset();
        test_target_zero("zero");
        test_target_max();
        test_first_probe_hit();
        test_beyond_range();
`ifndef SAR_ONEHOT_CHECK_EN
        test_no_flags();
`endif
        test_reset_mid_search();
        ignore_starts = 1;
        test_target_zero("b2b");
        ignore_starts = 0;
`ifdef SAR_ONEHOT_CHECK_EN
        test_onehot_abort();
`endif
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
